// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, status and PS/2 pin signals of the host transmitter
interface ps2_host_tx_if;
  logic       start;
  logic [7:0] data;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       error;
  modport master (
    output start, data, ps2_clk, ps2_data,
    input  ps2_clk_oe, ps2_data_oe, busy, done, error
  );
  modport slave (
    input  start, data, ps2_clk, ps2_data,
    output ps2_clk_oe, ps2_data_oe, busy, done, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from host to PS/2 device over open-drain clock/data pins
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic         clk_i,
  input logic         rst_i,
  ps2_host_tx_if.slave bus
);
  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic          doe_q, doe_d;
  logic          flag_q, flag_d;
  logic          err_q, err_d;
  logic [1:0]    clk_s_q, dat_s_q;
  logic          clk_prev_q;
  logic          fe, timeout, inh_last;
  assign fe       = clk_prev_q & ~clk_s_q[1];
  assign timeout  = tcnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign inh_last = icnt_q == IW'(INHIBIT_CYCLES - 1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      icnt_q     <= '0;
      tcnt_q     <= '0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      doe_q      <= 1'b0;
      flag_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_s_q    <= '0;
      dat_s_q    <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      icnt_q     <= icnt_d;
      tcnt_q     <= tcnt_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      doe_q      <= doe_d;
      flag_q     <= flag_d;
      err_q      <= err_d;
      clk_s_q    <= {clk_s_q[0], bus.ps2_clk};
      dat_s_q    <= {dat_s_q[0], bus.ps2_data};
      clk_prev_q <= clk_s_q[1];
    end
  end
  always_comb begin
    state_d  = state_q;
    icnt_d   = icnt_q;
    tcnt_d   = tcnt_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    doe_d    = doe_q;
    flag_d   = flag_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        shift_d = {1'b1, ~^bus.data, bus.data};
        err_d   = 1'b0;
        flag_d  = 1'b0;
        icnt_d  = '0;
        state_d = INHIBIT;
      end
      INHIBIT: begin
        icnt_d = icnt_q + IW'(1);
        if (inh_last) begin
          tcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ, SHIFT, ACK, WAIT_IDLE: begin
        tcnt_d = tcnt_q + TW'(1);
        // timeout wins over a falling edge seen in the same cycle
        if (timeout) begin
          doe_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (state_q == WAIT_IDLE) begin
          if (clk_s_q[1] && dat_s_q[1]) begin
            err_d   = flag_q;
            state_d = DONE;
          end
        end else if (fe && state_q == ACK) begin
          flag_d  = dat_s_q[1];
          state_d = WAIT_IDLE;
        end else if (fe) begin
          doe_d    = ~shift_q[0];
          shift_d  = shift_q >> 1;
          bitcnt_d = state_q == REQ ? 4'd1 : bitcnt_q + 4'd1;
          state_d  = state_q == REQ ? SHIFT : bitcnt_q == 4'd9 ? ACK : SHIFT;
        end
      end
      DONE: begin
        doe_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.ps2_clk_oe  = state_q == INHIBIT;
  assign bus.ps2_data_oe = (state_q == INHIBIT && inh_last) || state_q == REQ || (state_q == SHIFT && doe_q);
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = state_q == DONE;
  assign bus.error       = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed checks of the PS/2 host transmitter against a simple device model
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO  = 600;
  localparam int H   = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic last_err = 1'b0;
  logic [1:0] last_oe = 2'b00;
  logic [10:0] f;
  logic e;
  int n, m, n0;
  ps2_host_tx_if bus();
  assign bus.ps2_clk  = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data = dev_data & ~bus.ps2_data_oe;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done) begin
    done_cnt++;
    last_err = bus.error;
    last_oe  = {bus.ps2_clk_oe, bus.ps2_data_oe};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_oe(input string tag, input logic want);
    for (int t = 0; t < 3000 && bus.ps2_clk_oe !== want; t++) @(negedge clk);
    chk(tag, bus.ps2_clk_oe, want);
  endtask
  task automatic device(input logic ack, output logic [10:0] fr);
    wait_oe("req_inhibit", 1'b1);
    wait_oe("req_release", 1'b0);
    repeat (H) @(negedge clk);
    fr[0] = bus.ps2_data;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      fr[i] = bus.ps2_data;
      repeat (H) @(negedge clk);
    end
    dev_data = ~ack;
    dev_clk  = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (H) @(negedge clk);
    dev_data = 1'b1;
  endtask
  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    bus.data  = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic xfer(input logic [7:0] d, input logic ack, output logic [10:0] fr, output logic err);
    int c0;
    c0 = done_cnt;
    pulse_start(d);
    device(ack, fr);
    for (int t = 0; t < 100 && done_cnt == c0; t++) @(negedge clk);
    chk("done_seen", done_cnt - c0, 1);
    err = last_err;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", bus.ps2_clk_oe, 0);
    chk("rst_data_oe", bus.ps2_data_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    xfer(8'hED, 1'b1, f, e);
    chk("ed_frame", f, 11'b11_11101101_0);
    chk("ed_parity", f[9], 1);
    chk("ed_error", e, 0);
    chk("ed_release", last_oe, 0);
    xfer(8'h01, 1'b1, f, e);
    chk("01_frame", f, 11'b10_00000001_0);
    chk("01_parity", f[9], 0);
    chk("01_error", e, 0);
    xfer(8'h00, 1'b1, f, e);
    chk("00_frame", f, 11'b11_00000000_0);
    chk("00_parity", f[9], 1);
    chk("00_error", e, 0);
    xfer(8'hFF, 1'b0, f, e);
    chk("nack_frame", f, 11'b11_11111111_0);
    chk("nack_error", e, 1);
    chk("nack_release", last_oe, 0);
    pulse_start(8'h55);
    n = 0;
    while (bus.ps2_clk_oe && n < 5000) begin
      n++;
      @(negedge clk);
    end
    m = 0;
    while (!bus.done && m < 5000) begin
      @(negedge clk);
      m++;
    end
    chk("inhibit_len", n, INH);
    chk("timeout_len", m, TO);
    chk("timeout_error", bus.error, 1);
    chk("timeout_release", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    repeat (3) @(negedge clk);
    pulse_start(8'h00);
    wait_oe("rst_req_inhibit", 1'b1);
    wait_oe("rst_req_release", 1'b0);
    repeat (H) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    chk("mid_bit4_oe", bus.ps2_data_oe, 1);
    chk("mid_busy", bus.busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_clk_oe", bus.ps2_clk_oe, 0);
    chk("mid_rst_data_oe", bus.ps2_data_oe, 0);
    chk("mid_rst_busy", bus.busy, 0);
    dev_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    xfer(8'h3C, 1'b1, f, e);
    chk("after_rst_frame", f, 11'b11_00111100_0);
    chk("after_rst_error", e, 0);
    pulse_start(8'hA5);
    n0 = done_cnt;
    fork
      device(1'b1, f);
      begin
        repeat (4) @(negedge clk);
        bus.data  = 8'hFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (60) @(negedge clk);
        bus.data  = 8'h12;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    repeat (100) @(negedge clk);
    chk("busy_frame", f, 11'b11_10100101_0);
    chk("busy_done_count", done_cnt - n0, 1);
    chk("busy_error", last_err, 0);
    chk("busy_idle", bus.busy, 0);
    chk("busy_clk_oe", bus.ps2_clk_oe, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
